// File: rtl/seg7_scan_sched_pkg.sv
// Shared constants, types and the leading-zero blanking helper for the
// 4-digit 7-segment scan scheduler.
package seg7_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_STEADY = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_DIG [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef enum logic {
        ST_OFF,
        ST_SCAN
    } scan_state_e;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
    } frame_t;

    // Bit n set means digit n is suppressed; digit0 is always shown.
    function automatic logic [3:0] lz_blank(input frame_t f, input logic en);
        logic z3, z32, z321;
        z3   = (f.bcd[15:12] == 4'd0);
        z32  = z3 && (f.bcd[11:8] == 4'd0);
        z321 = z32 && (f.bcd[7:4] == 4'd0);
        return {en && z3, en && z32, en && z321, 1'b0};
    endfunction

endpackage

// File: rtl/seg7_scan_sched_if.sv
// Frame update handshake between a frame source and the scan scheduler.
interface seg7_scan_sched_if;

    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_bcd;
    logic [3:0]  upd_dp;

    modport master (output upd_valid, upd_bcd, upd_dp, input upd_ready);
    modport slave  (input upd_valid, upd_bcd, upd_dp, output upd_ready);

endinterface

// File: rtl/seg7_tick_div.sv
// Scan-slot prescaler: one-cycle tick every SCAN_DIV enabled clocks, held at 0 when disabled.
module seg7_tick_div #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_sched.sv
// Scan scheduler for a 4-digit 7-segment display: double-buffered BCD frame,
// paced digit scan, steady/blink/off modes and leading-zero blanking.
module seg7_scan_sched
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_sched_if.slave upd,
    input  logic [1:0]       mode,
    input  logic             lzb_en,
    output logic [1:0]       digit_sel,
    output logic [3:0]       bcd_out,
    output logic             dp_n,
    output logic [3:0]       an_n,
    output logic             frame_done
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    scan_state_e   state;
    frame_t        active;
    frame_t        pending;
    frame_t        frame_nxt;
    logic          pend_full;
    logic          tick;
    logic          scan_en;
    logic          eof;
    logic          swap;
    logic          accept;
    logic          vis;
    logic          dp_bit;
    logic [1:0]    nxt;
    logic [3:0]    blank;
    logic [3:0]    nib;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // While OFF the prescaler only runs once a non-off mode is requested,
    // so the switch into SCAN lands on a slot boundary.
    assign scan_en = (state == ST_SCAN) || (mode != MODE_OFF);

    seg7_tick_div #(.SCAN_DIV(SCAN_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (scan_en),
        .tick (tick)
    );

    assign upd.upd_ready = ~pend_full;

    // Outputs for the slot being entered are built from the frame that will be
    // active after this edge, so a swapped-in frame is shown from its digit0.
    always_comb begin
        accept    = upd.upd_valid && !pend_full;
        eof       = tick && (state == ST_SCAN) && (digit_sel == 2'd3);
        swap      = pend_full && ((state == ST_OFF) || eof);
        frame_nxt = swap ? pending : active;
        nxt       = (state == ST_SCAN) ? digit_sel + 2'd1 : 2'd0;
        nib       = frame_nxt.bcd[{nxt, 2'b00} +: 4];
        dp_bit    = frame_nxt.dp[nxt];
        blank     = lz_blank(frame_nxt, lzb_en);
        vis       = !blank[nxt] && !((mode == MODE_BLINK) && !blink_phase);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            active      <= '0;
            pending     <= '0;
            pend_full   <= 1'b0;
            digit_sel   <= '0;
            bcd_out     <= '0;
            dp_n        <= 1'b1;
            an_n        <= AN_OFF;
            frame_done  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            frame_done <= eof;

            if (swap) begin
                active <= pending;
            end

            if (accept) begin
                pending   <= '{bcd: upd.upd_bcd, dp: upd.upd_dp};
                pend_full <= 1'b1;
            end else if (swap) begin
                pend_full <= 1'b0;
            end

            if (tick) begin
                if (mode == MODE_OFF) begin
                    state       <= ST_OFF;
                    digit_sel   <= '0;
                    bcd_out     <= '0;
                    dp_n        <= 1'b1;
                    an_n        <= AN_OFF;
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                end else begin
                    state     <= ST_SCAN;
                    digit_sel <= nxt;
                    bcd_out   <= nib;
                    dp_n      <= vis ? ~dp_bit : 1'b1;
                    an_n      <= vis ? AN_DIG[nxt] : AN_OFF;
                    if (state == ST_SCAN) begin
                        if (mode == MODE_BLINK) begin
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt   <= '0;
                                blink_phase <= ~blink_phase;
                            end else begin
                                blink_cnt <= blink_cnt + BW'(1);
                            end
                        end else begin
                            blink_cnt   <= '0;
                            blink_phase <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Directed bench for seg7_scan_sched with SCAN_DIV=4, BLINK_DIV=2.
module tb_seg7_scan_sched;
    import seg7_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       lzb_en;
    logic [1:0] digit_sel;
    logic [3:0] bcd_out;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_done;

    always #5 clk = ~clk;

    seg7_scan_sched_if upd_if ();

    seg7_scan_sched #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd       (upd_if),
        .mode      (mode),
        .lzb_en    (lzb_en),
        .digit_sel (digit_sel),
        .bcd_out   (bcd_out),
        .dp_n      (dp_n),
        .an_n      (an_n),
        .frame_done(frame_done)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [3:0]  an_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic        lzb;
        logic [15:0] an;
        logic [3:0]  dpn;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_an"},    16'(an_n),             16'hF);
        chk({pfx, "_sel"},   16'(digit_sel),        16'h0);
        chk({pfx, "_bcd"},   16'(bcd_out),          16'h0);
        chk({pfx, "_dp"},    16'(dp_n),             16'h1);
        chk({pfx, "_fd"},    16'(frame_done),       16'h0);
        chk({pfx, "_ready"}, 16'(upd_if.upd_ready), 16'h1);
    endtask

    task automatic offer(input logic [15:0] bcd, input logic [3:0] dp, input string name);
        int unsigned n = 0;
        while (!upd_if.upd_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rdy"}, 16'(upd_if.upd_ready), 16'h1);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_bcd   = bcd;
        upd_if.upd_dp    = dp;
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        chk({name, "_rdy_low"}, 16'(upd_if.upd_ready), 16'h0);
    endtask

    task automatic wait_fd(input string name);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        chk({name, "_fd"}, 16'(frame_done), 16'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0010, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1101};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b1111, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1110};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};
        vecs[4] = '{16'h0A05, 4'b1000, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111};
        vecs[5] = '{16'h0100, 4'b0110, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1001};
        vecs[6] = '{16'hF009, 4'b0001, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1110};

        rst_n            = 1'b0;
        mode             = MODE_STEADY;
        lzb_en           = 1'b0;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_bcd   = '0;
        upd_if.upd_dp    = '0;
        #12;
        chk_reset("rst");

        // Scan start-up: dark until the first tick, then one digit per 4 clk.
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 1; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("start_an_%0d", k), 16'(an_n),
                16'((k < 4) ? 4'hF : an_dig[((k - 4) / 4) % 4]));
            chk($sformatf("start_fd_%0d", k), 16'(frame_done), 16'(k == 20));
        end

        for (int i = 0; i < 7; i++) begin
            lzb_en = vecs[i].lzb;
            offer(vecs[i].bcd, vecs[i].dp, $sformatf("v%0d", i));
            wait_fd($sformatf("v%0d", i));
            chk($sformatf("v%0d_ready", i), 16'(upd_if.upd_ready), 16'h1);
            for (int d = 0; d < 4; d++) begin
                if (d > 0) repeat (4) @(negedge clk);
                chk($sformatf("v%0d_sel%0d", i, d), 16'(digit_sel), 16'(d));
                chk($sformatf("v%0d_an%0d", i, d),  16'(an_n),      16'(vecs[i].an[d*4 +: 4]));
                chk($sformatf("v%0d_bcd%0d", i, d), 16'(bcd_out),   16'(vecs[i].bcd[d*4 +: 4]));
                chk($sformatf("v%0d_dp%0d", i, d),  16'(dp_n),      16'(vecs[i].dpn[d]));
            end
        end

        // Blink: 2 ticks lit, 2 dark; back to steady while dark.
        wait_fd("blink_align");
        mode = MODE_BLINK;
        for (int unsigned k = 1; k <= 11; k++) begin
            if (k == 8) mode = MODE_STEADY;
            repeat (4) @(negedge clk);
            chk($sformatf("blink_an_%0d", k), 16'(an_n),
                16'(((k >= 8) || (((k - 1) / 2) % 2 == 0)) ? an_dig[k % 4] : 4'hF));
        end

        // Offers while not ready are dropped.
        lzb_en = 1'b0;
        offer(16'h4321, 4'h0, "hold");
        upd_if.upd_valid = 1'b1;
        upd_if.upd_bcd   = 16'h8888;
        upd_if.upd_dp    = 4'hF;
        repeat (2) @(negedge clk);
        chk("hold_busy_rdy", 16'(upd_if.upd_ready), 16'h0);
        upd_if.upd_valid = 1'b0;
        wait_fd("hold_a");
        chk("hold_a_bcd", 16'(bcd_out), 16'h1);
        wait_fd("hold_b");
        chk("hold_b_bcd",   16'(bcd_out),          16'h1);
        chk("hold_b_dp",    16'(dp_n),             16'h1);
        chk("hold_b_ready", 16'(upd_if.upd_ready), 16'h1);

        // Accept on the frame_done edge waits a whole frame.
        repeat (15) @(negedge clk);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_bcd   = 16'h5678;
        upd_if.upd_dp    = 4'h0;
        @(negedge clk);
        upd_if.upd_valid = 1'b0;
        chk("coin_fd",    16'(frame_done),       16'h1);
        chk("coin_old",   16'(bcd_out),          16'h1);
        chk("coin_ready", 16'(upd_if.upd_ready), 16'h0);
        wait_fd("coin_next");
        chk("coin_new", 16'(bcd_out),   16'h8);
        chk("coin_sel", 16'(digit_sel), 16'h0);

        // Asynchronous reset in the digit2 slot discards the pending frame.
        offer(16'h9999, 4'hF, "rstp");
        repeat (8) @(negedge clk);
        chk("rstp_sel", 16'(digit_sel), 16'h2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_an",  16'(an_n),    16'hE);
        chk("post_bcd", 16'(bcd_out), 16'h0);
        wait_fd("post");
        chk("post_frame_bcd", 16'(bcd_out),          16'h0);
        chk("post_frame_an",  16'(an_n),             16'hE);
        chk("post_ready",     16'(upd_if.upd_ready), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
